// File: rtl/mult_div_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package mult_div_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FINISH
  } state_t;

  // Booth recoding of {Q[0], Q-1}
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem < divisor keeps the true difference inside a WIDTH+1 bit signed range
  assign shifted = {rem, quot[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    rem_next  = shifted[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_next  = diff[WIDTH-1:0];
      quot_next = {quot[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// HI/LO sequencer: signed radix-2 Booth multiply and restoring signed divide.
import mult_div_pkg::*;

module mult_div_ctrl #(
  parameter int WIDTH = ITER,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multControl,
  input  logic             divControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic last;

  logic signed [WIDTH-1:0] mcand;
  logic signed [WIDTH:0]   acc;
  logic signed [WIDTH:0]   mcand_x;
  logic signed [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0]        q;
  logic                    q_m1;

  logic [WIDTH-1:0] rem, quot, dvsr, rem_nx, quot_nx;
  logic             neg_q, neg_r, op_div;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (multControl)                 state_nx = MULT;
        else if (divControl && b != '0)  state_nx = DIV;
      end
      MULT:   if (last) state_nx = FINISH;
      DIV:    if (last) state_nx = FINISH;
      FINISH: state_nx = IDLE;
    endcase
  end

  // Accumulator is one bit wider so subtracting the most negative multiplicand cannot wrap
  assign mcand_x = {mcand[WIDTH-1], mcand};

  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      BOOTH_ADD: booth_sum = acc + mcand_x;
      BOOTH_SUB: booth_sum = acc - mcand_x;
      default:   booth_sum = acc;
    endcase
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quot     (quot),
    .divisor  (dvsr),
    .rem_next (rem_nx),
    .quot_next(quot_nx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      cnt     <= '0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (multControl || (divControl && b != '0)) begin
            cnt  <= '0;
            busy <= 1'b1;
          end else if (divControl) begin
            divZero <= 1'b1;
            done    <= 1'b1;
          end
        end
        MULT, DIV: cnt <= cnt + CNT_W'(1);
        FINISH: begin
          if (op_div) begin
            lo <= cond_neg(quot, neg_q);
            hi <= cond_neg(rem, neg_r);
          end else begin
            hi <= acc[WIDTH-1:0];
            lo <= q;
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (multControl) begin
          mcand  <= a;
          q      <= b;
          acc    <= '0;
          q_m1   <= 1'b0;
          op_div <= 1'b0;
        end else if (divControl && b != '0) begin
          rem    <= '0;
          quot   <= mag(a);
          dvsr   <= mag(b);
          neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r  <= a[WIDTH-1];
          op_div <= 1'b1;
        end
      end
      MULT: begin
        acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q    <= {booth_sum[0], q[WIDTH-1:1]};
        q_m1 <= q[0];
      end
      DIV: begin
        rem  <= rem_nx;
        quot <= quot_nx;
      end
      FINISH: ;
    endcase
  end

endmodule
